// File: rtl/titan_lsu_pkg.sv
// Shared types and helpers for the Titan load/store unit.
//  size_e   : access size encoding (byte/half/word/dword)
//  state_e  : bus FSM states
//  sel_mask : right-aligned byte-enable mask for a size
//  align_mask: address bits that must be zero for a naturally aligned access
//  ext_data : sign/zero extension of right-aligned load data
package titan_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StStBus,
    StLdBus
  } state_e;

  function automatic logic [7:0] sel_mask(size_e sz);
    logic [7:0] m;
    unique case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] align_mask(size_e sz);
    logic [2:0] m;
    unique case (sz)
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] ext_data(logic [63:0] d, size_e sz, logic uns);
    logic [63:0] r;
    unique case (sz)
      SZ_B:    r = uns ? {56'b0, d[7:0]}  : {{56{d[7]}}, d[7:0]};
      SZ_H:    r = uns ? {48'b0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      SZ_W:    r = uns ? {32'b0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/titan_lsu_wb_if.sv
// Pipeline request/response and Wishbone-classic signals of the Titan LSU.
//  master : the LSU's view (drives req_ready/rsp/st_err and the WB master outputs)
//  slave  : the environment's view (pipeline plus WB slave)
interface titan_lsu_wb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [AW-1:0]     req_addr_i;
  logic [DW-1:0]     req_wdata_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic              kill_i;
  logic              rsp_valid_o;
  logic [DW-1:0]     rsp_rdata_o;
  logic              rsp_err_o;
  logic              rsp_misalign_o;
  logic              st_err_o;
  logic [DW-1:0]     dat_i;
  logic              ack_i;
  logic              err_i;
  logic [AW-1:0]     adr_o;
  logic [DW-1:0]     dat_o;
  logic [DW/8-1:0]   sel_o;
  logic              cyc_o;
  logic              stb_o;
  logic              we_o;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i, kill_i,
    input  dat_i, ack_i, err_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misalign_o, st_err_o,
    output adr_o, dat_o, sel_o, cyc_o, stb_o, we_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i, kill_i,
    output dat_i, ack_i, err_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misalign_o, st_err_o,
    input  adr_o, dat_o, sel_o, cyc_o, stb_o, we_o
  );
endinterface

// File: rtl/titan_lsu_sbuf.sv
// Store buffer: synchronous FIFO of packed {adr, dat, sel} entries.
//  push_i/wdata_i : enqueue (ignored when full)
//  pop_i          : dequeue head (ignored when empty)
//  rdata_o        : current head entry
//  full_o/empty_o : occupancy flags
module titan_lsu_sbuf #(
  parameter int unsigned EW    = 68,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [EW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [EW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d = wptr_q + PW'(push_ok);
    rptr_d = rptr_q + PW'(pop_ok);
    cnt_d  = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/titan_lsu_wb.sv
// Titan load/store unit, Wishbone-classic data port.
//  clk_i/rst_ni : clock, asynchronous active-low reset
//  bus          : titan_lsu_wb_if.master (pipeline req/rsp, kill, WB master signals)
// Stores are posted into titan_lsu_sbuf and answered the next cycle; loads issue only
// once the buffer has drained. Optional bus timeout: define TITAN_LSU_TIMEOUT_EN.
module titan_lsu_wb
  import titan_lsu_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned TMO_CYC  = 255
) (
  input logic           clk_i,
  input logic           rst_ni,
  titan_lsu_wb_if.master bus
);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned OW = $clog2(SW);
  localparam int unsigned EW = AW + DW + SW;

  state_e          state_q, state_d;
  logic            rdy_en_q;
  logic            ld_kill_q, ld_kill_d, ld_uns_q, ld_uns_d;
  size_e           ld_size_q, ld_size_d;
  logic [OW-1:0]   ld_off_q, ld_off_d;
  logic [AW-1:0]   ld_adr_q, ld_adr_d;
  logic [SW-1:0]   ld_sel_q, ld_sel_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_mis_q, rsp_mis_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            st_err_q, st_err_d;

  size_e           req_size;
  logic [OW-1:0]   req_off;
  logic            misalign, accept, ld_live, term, err_eff, tmo;
  logic [7:0]      sel8;
  logic [AW-1:0]   req_adr;
  logic [DW-1:0]   push_dat, head_dat, ld_shift;
  logic [SW-1:0]   push_sel, head_sel;
  logic [AW-1:0]   head_adr;
  logic [EW-1:0]   head_entry;
  logic            sb_full, sb_empty;
  logic [63:0]     ld_ext;

  assign req_size = size_e'(bus.req_size_i);
  assign req_off  = bus.req_addr_i[OW-1:0];
  assign misalign = ((bus.req_addr_i[2:0] & align_mask(req_size)) != 3'b000) ||
                    ((req_size == SZ_D) && (DW == 32));
  assign sel8     = sel_mask(req_size) << req_off;
  assign push_sel = sel8[SW-1:0];
  assign push_dat = bus.req_wdata_i << {req_off, 3'b000};
  assign req_adr  = {bus.req_addr_i[AW-1:OW], {OW{1'b0}}};

  // A live (unkilled) load owns the response slot, so nothing else is accepted meanwhile.
  assign ld_live  = (state_q == StLdBus) && !ld_kill_q;

  always_comb begin
    if (!rdy_en_q)         bus.req_ready_o = 1'b0;
    else if (misalign)     bus.req_ready_o = !ld_live;
    else if (bus.req_we_i) bus.req_ready_o = !sb_full && !ld_live;
    else                   bus.req_ready_o = sb_empty && (state_q == StIdle);
  end

  assign accept  = bus.req_valid_i && bus.req_ready_o;
  assign term    = (state_q != StIdle) && (bus.ack_i || bus.err_i || tmo);
  assign err_eff = bus.err_i || tmo;

  titan_lsu_sbuf #(
    .EW    (EW),
    .DEPTH (SB_DEPTH)
  ) u_sbuf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept && bus.req_we_i && !misalign),
    .wdata_i ({req_adr, push_dat, push_sel}),
    .pop_i   ((state_q == StStBus) && term),
    .rdata_o (head_entry),
    .full_o  (sb_full),
    .empty_o (sb_empty)
  );

  assign {head_adr, head_dat, head_sel} = head_entry;

`ifdef TITAN_LSU_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo = (state_q != StIdle) && (tmo_cnt_q == TW'(TMO_CYC - 1));

  always_comb begin
    tmo_cnt_d = ((state_q == StIdle) || term) ? '0 : tmo_cnt_q + TW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  assign ld_shift = bus.dat_i >> {ld_off_q, 3'b000};
  assign ld_ext   = ext_data(64'(ld_shift), ld_size_q, ld_uns_q);

  always_comb begin
    state_d     = state_q;
    ld_kill_d   = ld_kill_q;
    ld_uns_d    = ld_uns_q;
    ld_size_d   = ld_size_q;
    ld_off_d    = ld_off_q;
    ld_adr_d    = ld_adr_q;
    ld_sel_d    = ld_sel_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_mis_d   = 1'b0;
    rsp_rdata_d = '0;
    st_err_d    = 1'b0;

    if (accept && misalign) begin
      rsp_valid_d = 1'b1;
      rsp_mis_d   = 1'b1;
    end else if (accept && bus.req_we_i) begin
      rsp_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (!sb_empty) begin
          state_d = StStBus;
        end else if (accept && !bus.req_we_i && !misalign) begin
          // Go straight to the bus so cyc_o rises the cycle after acceptance.
          state_d   = StLdBus;
          ld_kill_d = bus.kill_i;
          ld_uns_d  = bus.req_unsigned_i;
          ld_size_d = req_size;
          ld_off_d  = req_off;
          ld_adr_d  = req_adr;
          ld_sel_d  = push_sel;
        end
      end
      StStBus: begin
        if (term) begin
          state_d  = StIdle;
          st_err_d = err_eff;
        end
      end
      StLdBus: begin
        if (bus.kill_i) ld_kill_d = 1'b1;
        if (term) begin
          state_d   = StIdle;
          ld_kill_d = 1'b0;
          if (!ld_kill_q && !bus.kill_i) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_eff;
            rsp_rdata_d = err_eff ? '0 : ld_ext[DW-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      rdy_en_q    <= 1'b0;
      ld_kill_q   <= 1'b0;
      ld_uns_q    <= 1'b0;
      ld_size_q   <= SZ_B;
      ld_off_q    <= '0;
      ld_adr_q    <= '0;
      ld_sel_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_mis_q   <= 1'b0;
      rsp_rdata_q <= '0;
      st_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      ld_kill_q   <= ld_kill_d;
      ld_uns_q    <= ld_uns_d;
      ld_size_q   <= ld_size_d;
      ld_off_q    <= ld_off_d;
      ld_adr_q    <= ld_adr_d;
      ld_sel_q    <= ld_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_rdata_q <= rsp_rdata_d;
      st_err_q    <= st_err_d;
    end
  end

  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.rsp_err_o      = rsp_err_q;
  assign bus.rsp_misalign_o = rsp_mis_q;
  assign bus.rsp_rdata_o    = rsp_rdata_q;
  assign bus.st_err_o       = st_err_q;

  // Bus outputs come from registered state only, so they stay stable through a cycle.
  always_comb begin
    bus.cyc_o = 1'b0;
    bus.stb_o = 1'b0;
    bus.we_o  = 1'b0;
    bus.adr_o = '0;
    bus.dat_o = '0;
    bus.sel_o = '0;
    unique case (state_q)
      StStBus: begin
        bus.cyc_o = 1'b1;
        bus.stb_o = 1'b1;
        bus.we_o  = 1'b1;
        bus.adr_o = head_adr;
        bus.dat_o = head_dat;
        bus.sel_o = head_sel;
      end
      StLdBus: begin
        bus.cyc_o = 1'b1;
        bus.stb_o = 1'b1;
        bus.adr_o = ld_adr_q;
        bus.sel_o = ld_sel_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_titan_lsu_wb.sv
module tb_titan_lsu_wb;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  titan_lsu_wb_if #(.AW(32), .DW(32)) bus ();

  titan_lsu_wb #(
    .AW       (32),
    .DW       (32),
    .SB_DEPTH (4),
    .TMO_CYC  (255)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdat;   // WB read data returned for loads
    logic        mis;    // expected misalign response
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;    // expected dat_o for stores
    logic [31:0] rdata;  // expected rsp_rdata
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wdata;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_st;
    logic acc;
    int cnt;

    vecs[0]  = '{1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'h8000_00F0, 1'b0, 4'hF, 32'h100, 32'h0,
                 32'h8000_00F0};
    vecs[1]  = '{1'b0, 32'h103, 32'h0,        2'b00, 1'b0, 32'h80FF_FFFF, 1'b0, 4'h8, 32'h100, 32'h0,
                 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 32'h103, 32'h0,        2'b00, 1'b1, 32'h80FF_FFFF, 1'b0, 4'h8, 32'h100, 32'h0,
                 32'h0000_0080};
    vecs[3]  = '{1'b1, 32'h102, 32'hBEEF,     2'b01, 1'b0, 32'h0,         1'b0, 4'hC, 32'h100,
                 32'hBEEF_0000, 32'h0};
    vecs[4]  = '{1'b0, 32'h101, 32'h0,        2'b10, 1'b0, 32'h0,         1'b1, 4'h0, 32'h0, 32'h0,
                 32'h0};
    vecs[5]  = '{1'b0, 32'h102, 32'h0,        2'b01, 1'b0, 32'h8001_1234, 1'b0, 4'hC, 32'h100, 32'h0,
                 32'hFFFF_8001};
    vecs[6]  = '{1'b0, 32'h100, 32'h0,        2'b01, 1'b1, 32'h1234_F00D, 1'b0, 4'h3, 32'h100, 32'h0,
                 32'h0000_F00D};
    vecs[7]  = '{1'b1, 32'h105, 32'hAB,       2'b00, 1'b0, 32'h0,         1'b0, 4'h2, 32'h104,
                 32'h0000_AB00, 32'h0};
    vecs[8]  = '{1'b1, 32'h208, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0,        1'b0, 4'hF, 32'h208,
                 32'hDEAD_BEEF, 32'h0};
    vecs[9]  = '{1'b0, 32'h100, 32'h0,        2'b11, 1'b0, 32'h0,         1'b1, 4'h0, 32'h0, 32'h0,
                 32'h0};
    vecs[10] = '{1'b1, 32'h103, 32'h1234,     2'b01, 1'b0, 32'h0,         1'b1, 4'h0, 32'h0, 32'h0,
                 32'h0};
    vecs[11] = '{1'b0, 32'h101, 32'h0,        2'b00, 1'b0, 32'h0000_7F00, 1'b0, 4'h2, 32'h100, 32'h0,
                 32'h0000_007F};

    rst_n = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus.req_size_i = '0; bus.req_unsigned_i = 1'b0; bus.kill_i = 1'b0;
    bus.dat_i = '0; bus.ack_i = 1'b0; bus.err_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", bus.cyc_o, 0);
    chk("rst_stb", bus.stb_o, 0);
    chk("rst_ready", bus.req_ready_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_adr", bus.adr_o, 0);
    chk("rst_st_err", bus.st_err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();

    // Table-driven single transactions.
    for (int i = 0; i < 12; i++) begin
      set_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns);
      #1 chk($sformatf("v%0d_ready", i), bus.req_ready_o, 1);
      tick();
      bus.req_valid_i = 1'b0;
      #1;
      if (vecs[i].mis) begin
        chk($sformatf("v%0d_mis_rv", i), bus.rsp_valid_o, 1);
        chk($sformatf("v%0d_mis_flag", i), bus.rsp_misalign_o, 1);
        chk($sformatf("v%0d_mis_rdata", i), bus.rsp_rdata_o, 0);
        chk($sformatf("v%0d_mis_nocyc", i), bus.cyc_o, 0);
        tick();
        chk($sformatf("v%0d_mis_strobe", i), bus.rsp_valid_o, 0);
        chk($sformatf("v%0d_mis_nocyc2", i), bus.cyc_o, 0);
      end else if (vecs[i].we) begin
        chk($sformatf("v%0d_st_rv", i), bus.rsp_valid_o, 1);
        chk($sformatf("v%0d_st_mis", i), bus.rsp_misalign_o, 0);
        chk($sformatf("v%0d_st_cyc_early", i), bus.cyc_o, 0);
        tick();
        chk($sformatf("v%0d_st_cyc", i), bus.cyc_o, 1);
        chk($sformatf("v%0d_st_we", i), bus.we_o, 1);
        chk($sformatf("v%0d_st_sel", i), bus.sel_o, vecs[i].sel);
        chk($sformatf("v%0d_st_dat", i), bus.dat_o, vecs[i].dat);
        chk($sformatf("v%0d_st_adr", i), bus.adr_o, vecs[i].adr);
        chk($sformatf("v%0d_st_rv_off", i), bus.rsp_valid_o, 0);
        bus.ack_i = 1'b1;
        tick();
        bus.ack_i = 1'b0;
        #1 chk($sformatf("v%0d_st_cyc_drop", i), bus.cyc_o, 0);
      end else begin
        chk($sformatf("v%0d_ld_cyc", i), bus.cyc_o, 1);
        chk($sformatf("v%0d_ld_we", i), bus.we_o, 0);
        chk($sformatf("v%0d_ld_sel", i), bus.sel_o, vecs[i].sel);
        chk($sformatf("v%0d_ld_adr", i), bus.adr_o, vecs[i].adr);
        tick(); tick();
        bus.ack_i = 1'b1;
        bus.dat_i = vecs[i].rdat;
        #1 chk($sformatf("v%0d_ld_rv_early", i), bus.rsp_valid_o, 0);
        tick();
        bus.ack_i = 1'b0;
        bus.dat_i = '0;
        #1;
        chk($sformatf("v%0d_ld_rv", i), bus.rsp_valid_o, 1);
        chk($sformatf("v%0d_ld_rdata", i), bus.rsp_rdata_o, vecs[i].rdata);
        chk($sformatf("v%0d_ld_err", i), bus.rsp_err_o, 0);
        chk($sformatf("v%0d_ld_cyc_drop", i), bus.cyc_o, 0);
      end
      tick();
    end

    // Fill the store buffer with ack held low, then a load must wait for every store.
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 32'h300 + 32'(4 * i), 32'(i), 2'b10, 1'b0);
      #1 chk($sformatf("fill%0d_ready", i), bus.req_ready_o, 1);
      tick();
    end
    #1 chk("full_ready", bus.req_ready_o, 0);
    set_req(1'b0, 32'h400, 32'h0, 2'b10, 1'b0);
    n_st = 0;
    acc  = 1'b0;
    for (int c = 0; c < 60 && !acc; c++) begin
      bus.ack_i = bus.cyc_o && bus.we_o;
      if (bus.ack_i) begin
        chk($sformatf("drain%0d_adr", n_st), bus.adr_o, 32'h300 + 32'(4 * n_st));
        chk($sformatf("drain%0d_dat", n_st), bus.dat_o, 32'(n_st));
        n_st++;
      end
      #1 acc = bus.req_ready_o;
      tick();
    end
    chk("ld_behind_accept", acc, 1);
    chk("ld_behind_nstores", n_st, 4);
    bus.req_valid_i = 1'b0;
    bus.ack_i = 1'b0;
    #1;
    chk("ld_behind_cyc", bus.cyc_o, 1);
    chk("ld_behind_we", bus.we_o, 0);
    chk("ld_behind_adr", bus.adr_o, 32'h400);
    bus.ack_i = 1'b1;
    bus.dat_i = 32'h1122_3344;
    tick();
    bus.ack_i = 1'b0;
    #1 chk("ld_behind_rdata", bus.rsp_rdata_o, 32'h1122_3344);
    tick();

    // Killed load: bus cycle completes, no response.
    set_req(1'b0, 32'h500, 32'h0, 2'b10, 1'b0);
    tick();
    bus.req_valid_i = 1'b0;
    bus.kill_i = 1'b1;
    #1 chk("kill_cyc", bus.cyc_o, 1);
    tick();
    bus.kill_i = 1'b0;
    bus.ack_i = 1'b1;
    bus.dat_i = 32'hCAFE_F00D;
    #1 chk("kill_cyc_held", bus.cyc_o, 1);
    tick();
    bus.ack_i = 1'b0;
    #1;
    chk("kill_cyc_drop", bus.cyc_o, 0);
    chk("kill_no_rsp0", bus.rsp_valid_o, 0);
    tick();
    chk("kill_no_rsp1", bus.rsp_valid_o, 0);
    tick();

    // Store error with ack and err together: err wins, st_err pulses once.
    set_req(1'b1, 32'h600, 32'h55, 2'b10, 1'b0);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    bus.ack_i = 1'b1;
    bus.err_i = 1'b1;
    #1 chk("sterr_cyc", bus.cyc_o, 1);
    tick();
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    #1;
    chk("sterr_pulse", bus.st_err_o, 1);
    chk("sterr_cyc_drop", bus.cyc_o, 0);
    tick();
    chk("sterr_pulse_end", bus.st_err_o, 0);
    tick();

    // Load bus error: rsp_err set, data forced to zero.
    set_req(1'b0, 32'h604, 32'h0, 2'b10, 1'b0);
    tick();
    bus.req_valid_i = 1'b0;
    bus.err_i = 1'b1;
    bus.dat_i = 32'hFFFF_FFFF;
    tick();
    bus.err_i = 1'b0;
    #1;
    chk("lderr_rv", bus.rsp_valid_o, 1);
    chk("lderr_err", bus.rsp_err_o, 1);
    chk("lderr_rdata", bus.rsp_rdata_o, 0);
    tick();

    // No ack: with the timeout the cycle is abandoned after 255 cycles, otherwise it waits.
    set_req(1'b0, 32'h700, 32'h0, 2'b10, 1'b0);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    cnt = 0;
    while (bus.cyc_o && cnt < 400) begin
      cnt++;
      tick();
    end
`ifdef TITAN_LSU_TIMEOUT_EN
    chk("tmo_cycles", cnt, 255);
    chk("tmo_rv", bus.rsp_valid_o, 1);
    chk("tmo_err", bus.rsp_err_o, 1);
`else
    chk("notmo_still_cyc", bus.cyc_o, 1);
    chk("notmo_cycles", cnt, 400);
    bus.ack_i = 1'b1;
    bus.dat_i = 32'h0BAD_F00D;
    tick();
    bus.ack_i = 1'b0;
    #1 chk("notmo_rdata", bus.rsp_rdata_o, 32'h0BAD_F00D);
`endif
    tick();

    // Reset in the middle of a bus cycle drops cyc/stb without waiting for a clock edge.
    set_req(1'b0, 32'h800, 32'h0, 2'b10, 1'b0);
    tick();
    bus.req_valid_i = 1'b0;
    #1 chk("rstmid_cyc_before", bus.cyc_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_cyc", bus.cyc_o, 0);
    chk("rstmid_stb", bus.stb_o, 0);
    chk("rstmid_adr", bus.adr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    chk("rstmid_no_rsp", bus.rsp_valid_o, 0);
    chk("rstmid_idle", bus.cyc_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
